mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles for one owner while another requester waits; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 REQ  input  4  REQ[k] = requester k wants mux input Ik routed to D.
REQ-005 GNT  output 4  one-hot grant; GNT[k]=1 means requester k owns the mux; all-zero when no owner.
REQ-006 S1   output 1  mux select MSB, registered.
REQ-007 S0   output 1  mux select LSB, registered.
REQ-008 VALID output 1  1 when D carries the owner's input this cycle; equals |GNT.

Function
REQ-009 The block SHALL implement the states IDLE, GRANT and GAP.
REQ-010 Select encoding SHALL be {S1,S0} = 3-k for owner k: I3=00, I2=01, I1=10, I0=11.
REQ-011 Arbitration SHALL be round-robin: search starts at (LAST+1) mod 4 ascending with wrap; LAST is the most recent owner.
REQ-012 IDLE: GNT=0; if any REQ bit is sampled high, next cycle GRANT with the picked owner, so grant latency = 1 cycle from first sampled REQ.
REQ-013 On entering GRANT, GNT, S1/S0, LAST and hold counter (HCNT=1) SHALL update on the same edge.
REQ-014 GRANT, REQ[owner]=0 sampled: next cycle GAP.
REQ-015 GRANT, REQ[owner]=1, HCNT<MAX_HOLD: stay, HCNT+1.
REQ-016 GRANT, HCNT=MAX_HOLD, another REQ bit high: next cycle GAP (forced release).
REQ-017 GRANT, HCNT=MAX_HOLD, no other REQ: keep owner, HCNT reloads to 1; no GAP.
REQ-018 GAP lasts exactly 1 cycle with GNT=0, VALID=0, S1/S0 holding the last owner's code; then GRANT to newly picked owner if any REQ sampled high, else IDLE.
REQ-019 S1/S0 SHALL change only on entry to GRANT; they SHALL never change while GNT is non-zero.
REQ-020 GNT SHALL never have more than one bit set; no two owners in consecutive cycles without an intervening GAP.
REQ-021 HCNT width SHALL be 8 bits; it SHALL never exceed MAX_HOLD and never wrap.
REQ-022 REQ bits of non-owners SHALL be ignored during GRANT except for the REQ-016/017 decision.

Reset
REQ-023 RST high at a rising edge SHALL force, on that edge: state=IDLE, GNT=0000, VALID=0, {S1,S0}=00, LAST=3, HCNT=0.
REQ-024 RST asserted mid-GRANT or mid-GAP SHALL drop GNT the following cycle with no GAP; first post-reset priority is requester 0.
REQ-025 REQ sampled in the same cycle as RST SHALL be ignored.

Structure
REQ-026 Package mux4_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP), NUM_REQ=4, and the owner-to-select encoding function.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs REQ, LAST; outputs found, index).
REQ-028 The existing Mux4x1 SHALL be driven directly by S1/S0; the arbiter SHALL not contain the datapath.

Verification
REQ-029 Reset, REQ=0000 for 5 cycles -> GNT=0000, VALID=0, S1S0=00 every cycle.
REQ-030 After reset REQ=0101 held -> GNT=0001 (S1S0=11) one cycle later for 8 cycles, GAP, then GNT=0100 (S1S0=01) for 8 cycles, GAP, back to 0001.
REQ-031 REQ=0010 alone for 20 cycles -> GNT=0010, S1S0=10 continuous, no GAP at HCNT=8 reload.
REQ-032 Owner 3 drops REQ after 3 grant cycles with REQ[0]=1 -> one GAP cycle, then GNT=0001 (wrap from 3 to 0).
REQ-033 RST asserted during GRANT of owner 2 -> next cycle GNT=0000, S1S0=00; with REQ=1111 post-reset first grant is 0001.
REQ-034 MAX_HOLD=1, REQ=1111 -> grants 0001,GAP,0010,GAP,0100,GAP,1000,GAP repeating; one-hot and S1S0 stability checked every cycle.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-input round-robin mux arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Mux input Ik is selected by code 3-k (I3=00 ... I0=11).
    function automatic logic [1:0] owner_to_sel(input logic [1:0] owner);
        return 2'd3 - owner;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set req bit searching upward from last+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request bit is set.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic               found,
    output logic [1:0]         index
);

    // Scan last+1, last+2, last+3, last (the previous owner gets lowest priority).
    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        index = 2'd0;
        cand  = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for an external 4:1 mux, with hold limit and a one-cycle gap between owners.
// Latency: grant one cycle after a request is first sampled; select code registered with the grant.
// Backpressure: an owner is forced off after MAX_HOLD cycles only if another requester waits.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic               S1,
    output logic               S0,
    output logic               VALID
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt, gnt_nxt;
    logic [1:0]         sel, sel_nxt;
    logic [1:0]         last, last_nxt;
    logic [7:0]         hcnt, hcnt_nxt;
    logic               pick_found;
    logic [1:0]         pick_index;
    logic [NUM_REQ-1:0] others_req;

    rr_pick4 u_pick (
        .req   (REQ),
        .last  (last),
        .found (pick_found),
        .index (pick_index)
    );

    // Requests from everyone except the current owner (held in last during GRANT).
    assign others_req = REQ & ~(4'b0001 << last);

    // Next-state and next-output decision; all outputs are registered from these.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        hcnt_nxt  = hcnt;
        unique case (state)
            IDLE, GAP: begin
                gnt_nxt   = '0;
                hcnt_nxt  = 8'd0;
                state_nxt = IDLE;
                if (pick_found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << pick_index;
                    sel_nxt   = owner_to_sel(pick_index);
                    last_nxt  = pick_index;
                    hcnt_nxt  = 8'd1;
                end
            end
            GRANT: begin
                if (!REQ[last]) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    hcnt_nxt  = 8'd0;
                end else if (hcnt < MAX_HOLD_C) begin
                    hcnt_nxt  = hcnt + 8'd1;
                end else if (|others_req) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                    hcnt_nxt  = 8'd0;
                end else begin
                    // Nobody else waiting: keep the owner and start a fresh hold window.
                    hcnt_nxt  = 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                hcnt_nxt  = 8'd0;
            end
        endcase
    end

    // State register; reset wins over any request sampled on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= 2'b00;
            last  <= 2'd3;
            hcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    assign GNT   = gnt;
    assign S1    = sel[1];
    assign S0    = sel[0];
    assign VALID = |gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b;
    logic       s1_a, s0_a, s1_b, s0_b, valid_a, valid_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference state per instance: owner (-1 = nobody), last owner, cycles held, select code.
    int m_owner [2];
    int m_last  [2];
    int m_held  [2];
    int m_sel   [2];
    int m_hold  [2];

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req),
        .GNT(gnt_a), .S1(s1_a), .S0(s0_a), .VALID(valid_a)
    );

    mux4_rr_arbiter #(.MAX_HOLD(1)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req),
        .GNT(gnt_b), .S1(s1_b), .S0(s0_b), .VALID(valid_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock of the behavioural model: owner keeps the mux while it asks, unless its
    // hold budget is spent and someone else asks; with no owner, pick round-robin.
    task automatic model_step(input int n, input logic r, input logic [3:0] q);
        int o;
        if (r) begin
            m_owner[n] = -1;
            m_last[n]  = 3;
            m_held[n]  = 0;
            m_sel[n]   = 0;
            return;
        end
        o = m_owner[n];
        if (o >= 0) begin
            if (!q[o]) begin
                m_owner[n] = -1;
            end else if (m_held[n] < m_hold[n]) begin
                m_held[n]++;
            end else if ((q & ~(4'b0001 << o)) != 4'b0000) begin
                m_owner[n] = -1;
            end else begin
                m_held[n] = 1;
            end
        end else begin
            for (int i = 1; i <= 4; i++) begin
                int k;
                k = (m_last[n] + i) % 4;
                if (m_owner[n] < 0 && q[k]) begin
                    m_owner[n] = k;
                    m_last[n]  = k;
                    m_held[n]  = 1;
                    m_sel[n]   = 3 - k;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int n);
        return (m_owner[n] >= 0) ? (4'b0001 << m_owner[n]) : 4'b0000;
    endfunction

    // Apply one cycle of stimulus, advance the model on the edge, compare at the falling edge.
    task automatic cycle(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        model_step(0, r, q);
        model_step(1, r, q);
        @(negedge clk);
        check("gnt_a",   {4'b0, gnt_a},        {4'b0, exp_gnt(0)});
        check("sel_a",   {6'b0, s1_a, s0_a},   8'(m_sel[0]));
        check("valid_a", {7'b0, valid_a},      {7'b0, (m_owner[0] >= 0)});
        check("gnt_b",   {4'b0, gnt_b},        {4'b0, exp_gnt(1)});
        check("sel_b",   {6'b0, s1_b, s0_b},   8'(m_sel[1]));
        check("valid_b", {7'b0, valid_b},      {7'b0, (m_owner[1] >= 0)});
    endtask

    initial begin
        logic [3:0] rq;
        m_hold[0] = 8;
        m_hold[1] = 1;
        for (int n = 0; n < 2; n++) begin
            m_owner[n] = -1; m_last[n] = 3; m_held[n] = 0; m_sel[n] = 0;
        end
        rst = 1'b1;
        req = 4'b1111;

        // Reset with requests present (they must be ignored), then idle.
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000);

        // Two requesters sharing: hold limit alternation.
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 40; i++) cycle(1'b0, 4'b0101);

        // Lone requester: continuous grant across hold reloads.
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0010);

        // Owner 3 releases while requester 0 waits: gap then wrap to 0.
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1000);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1001);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0001);

        // Reset in the middle of owner 2's grant, then all request.
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0100);
        cycle(1'b1, 4'b1111);
        for (int i = 0; i < 40; i++) cycle(1'b0, 4'b1111);

        // Randomized traffic with occasional resets.
        rq = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 59) == 0), rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
